// File: rtl/deca_audio_pkg.sv
// Shared widths, frame geometry and stereo pair type for the DECA I2S path.
// Also holds the slot serialiser bit picker.
package deca_audio_pkg;

    localparam int SAMPLE_W   = 16;
    localparam int SLOT_W     = 32;
    localparam int FRAME_BITS = 2 * SLOT_W;
    localparam int BIT_W      = $clog2(FRAME_BITS);
    localparam int SEL_W      = $clog2(SAMPLE_W);

    typedef logic [SAMPLE_W-1:0] sample_t;

    typedef struct packed {
        sample_t left;
        sample_t right;
    } pair_t;

    // Bit sent at slot position pos: pad at 0, MSB..LSB at 1..SAMPLE_W, pad after.
    function automatic logic slot_bit(input sample_t s, input logic [BIT_W-2:0] pos);
        logic [SEL_W-1:0] sel;
        logic             b;
        sel = SEL_W'(SAMPLE_W - int'(pos));
        b   = 1'b0;
        if (pos != '0 && int'(pos) <= SAMPLE_W) begin
            b = s[sel];
        end
        return b;
    endfunction

endpackage

// File: rtl/stereo_fifo.sv
// Show-ahead synchronous FIFO of stereo pairs.
// Push is ignored when full, pop is ignored when empty.
module stereo_fifo
    import deca_audio_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  push,
    input  pair_t wdata,
    input  logic  pop,
    output pair_t rdata,
    output logic  full,
    output logic  empty
);

    localparam int AW = $clog2(DEPTH);

    pair_t         mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign rdata   = mem_q[rd_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (do_push) wr_d = wr_q + 1'b1;
        if (do_pop)  rd_d = rd_q + 1'b1;
        if (do_push && !do_pop) cnt_d = cnt_q + 1'b1;
        if (do_pop && !do_push) cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= wdata;
    end

endmodule

// File: rtl/deca_i2s_tx.sv
// I2S transmitter for the DECA codec: MCLK/BCLK/LRCLK generation and
// serialisation of buffered stereo pairs with one-bit I2S delay.
module deca_i2s_tx
    import deca_audio_pkg::*;
#(
    parameter int BCLK_DIV   = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                iCLK,
    input  logic                iRESET_n,
    input  logic                iVALID,
    input  logic [SAMPLE_W-1:0] iLEFT,
    input  logic [SAMPLE_W-1:0] iRIGHT,
    output logic                oREADY,
    input  logic                iMUTE,
    output logic                oMCLK,
    output logic                oBCLK,
    output logic                oLRCLK,
    output logic                oSDOUT,
    output logic                oUNDERRUN
);

    localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(BCLK_DIV - 1);

    logic             mclk_q, mclk_d;
    logic             bclk_q, bclk_d;
    logic             lrclk_q, lrclk_d;
    logic             sdout_q, sdout_d;
    logic             underrun_q, underrun_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [BIT_W-1:0] bit_q, bit_d, bit_nx;
    sample_t          left_q, left_d;
    sample_t          right_q, right_d;
    pair_t            last_q, last_d;
    pair_t            cur;
    pair_t            wr_pair;
    pair_t            fifo_rdata;
    logic             fifo_full, fifo_empty;
    logic             push, pop;

    assign wr_pair = '{left: iLEFT, right: iRIGHT};
    assign oREADY  = !fifo_full;
    assign push    = iVALID && !fifo_full;

    stereo_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (iCLK),
        .rst_n (iRESET_n),
        .push  (push),
        .wdata (wr_pair),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        mclk_d     = ~mclk_q;
        div_d      = div_q + 1'b1;
        bclk_d     = bclk_q;
        bit_d      = bit_q;
        lrclk_d    = lrclk_q;
        sdout_d    = sdout_q;
        underrun_d = 1'b0;
        left_d     = left_q;
        right_d    = right_q;
        last_d     = last_q;
        pop        = 1'b0;
        cur        = last_q;
        bit_nx     = bit_q + 1'b1;
        if (div_q == DIV_MAX) begin
            div_d  = '0;
            bclk_d = ~bclk_q;
            // Everything the codec sees changes on the BCLK falling edge.
            if (bclk_q) begin
                bit_d   = bit_nx;
                lrclk_d = bit_nx[BIT_W-1];
                sdout_d = bit_nx[BIT_W-1]
                        ? slot_bit(right_q, bit_nx[BIT_W-2:0])
                        : slot_bit(left_q, bit_nx[BIT_W-2:0]);
                if (bit_nx == '0) begin
                    if (fifo_empty) begin
                        underrun_d = 1'b1;
                    end else begin
                        pop    = 1'b1;
                        cur    = fifo_rdata;
                        last_d = fifo_rdata;
                    end
                    left_d  = iMUTE ? '0 : cur.left;
                    right_d = iMUTE ? '0 : cur.right;
                end
            end
        end
    end

    always_ff @(posedge iCLK or negedge iRESET_n) begin
        if (!iRESET_n) begin
            mclk_q     <= 1'b0;
            bclk_q     <= 1'b0;
            lrclk_q    <= 1'b1;
            sdout_q    <= 1'b0;
            underrun_q <= 1'b0;
            div_q      <= '0;
            bit_q      <= '1;
            left_q     <= '0;
            right_q    <= '0;
            last_q     <= '0;
        end else begin
            mclk_q     <= mclk_d;
            bclk_q     <= bclk_d;
            lrclk_q    <= lrclk_d;
            sdout_q    <= sdout_d;
            underrun_q <= underrun_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            left_q     <= left_d;
            right_q    <= right_d;
            last_q     <= last_d;
        end
    end

    assign oMCLK     = mclk_q;
    assign oBCLK     = bclk_q;
    assign oLRCLK    = lrclk_q;
    assign oSDOUT    = sdout_q;
    assign oUNDERRUN = underrun_q;

endmodule

// File: tb/tb_deca_i2s_tx.sv
// Bench for deca_i2s_tx: accepted pairs go to a scoreboard queue and are
// compared against frames decoded from the serial pins.
module tb_deca_i2s_tx;

    logic        iCLK = 1'b0;
    logic        iRESET_n = 1'b0;
    logic        iVALID = 1'b0;
    logic [15:0] iLEFT = '0;
    logic [15:0] iRIGHT = '0;
    logic        iMUTE = 1'b0;
    logic        oREADY, oMCLK, oBCLK, oLRCLK, oSDOUT, oUNDERRUN;

    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_p = '0;
    bit          mute_model = 0;

    deca_i2s_tx dut (
        .iCLK      (iCLK),
        .iRESET_n  (iRESET_n),
        .iVALID    (iVALID),
        .iLEFT     (iLEFT),
        .iRIGHT    (iRIGHT),
        .oREADY    (oREADY),
        .iMUTE     (iMUTE),
        .oMCLK     (oMCLK),
        .oBCLK     (oBCLK),
        .oLRCLK    (oLRCLK),
        .oSDOUT    (oSDOUT),
        .oUNDERRUN (oUNDERRUN)
    );

    always #5 iCLK = ~iCLK;

    always @(posedge iCLK or negedge iRESET_n) begin
        if (!iRESET_n) cyc <= 0;
        else           cyc <= cyc + 1;
    end

    function automatic logic [63:0] exp_bits(input logic [15:0] l, input logic [15:0] r);
        logic [63:0] e;
        e = '0;
        for (int k = 1; k <= 16; k++) begin
            e[k]      = l[16-k];
            e[32 + k] = r[16-k];
        end
        return e;
    endfunction

    task automatic model_next(output logic [63:0] e, output int ur);
        logic [31:0] p;
        if (exp_q.size() > 0) begin
            p = exp_q.pop_front();
            last_p = p;
            ur = 0;
        end else begin
            p = last_p;
            ur = 1;
        end
        if (mute_model) p = '0;
        e = exp_bits(p[31:16], p[15:0]);
    endtask

    task automatic do_reset();
        iVALID = 0;
        iMUTE = 0;
        @(negedge iCLK);
        iRESET_n = 0;
        repeat (3) @(negedge iCLK);
        iRESET_n = 1;
        exp_q.delete();
        last_p = '0;
        mute_model = 0;
    endtask

    // Called at a negedge; returns at a negedge.
    task automatic push_pair(input logic [15:0] l, input logic [15:0] r, output int acc);
        bit   ok;
        logic rd;
        ok = 0;
        acc = -1;
        iVALID = 1;
        iLEFT = l;
        iRIGHT = r;
        for (int i = 0; i < 3000 && !ok; i++) begin
            rd = oREADY;
            @(posedge iCLK);
            #1;
            if (rd) begin
                ok = 1;
                acc = cyc;
                exp_q.push_back({l, r});
            end
            @(negedge iCLK);
        end
        iVALID = 0;
        if (!ok) begin
            n_cmp++;
            n_fail++;
            $display("FAIL push_timeout got=no_accept want=accept");
        end
    endtask

    task automatic capture_frame(input int nbits, output logic [63:0] bits,
                                 output int fall_cyc, output int ur_cnt, output bit to);
        logic pb, plr;
        int   k, w;
        bits = '0;
        ur_cnt = 0;
        fall_cyc = -1;
        to = 0;
        plr = oLRCLK;
        for (w = 0; w < 2100; w++) begin
            @(negedge iCLK);
            if (plr && !oLRCLK) break;
            plr = oLRCLK;
        end
        if (w >= 2100) begin
            to = 1;
            return;
        end
        fall_cyc = cyc;
        ur_cnt = oUNDERRUN ? 1 : 0;
        pb = oBCLK;
        k = 0;
        w = 0;
        while (k < nbits && w < 200) begin
            @(negedge iCLK);
            w++;
            if (oUNDERRUN) ur_cnt++;
            if (!pb && oBCLK) begin
                bits[k] = oSDOUT;
                k++;
                w = 0;
            end
            pb = oBCLK;
        end
        if (k < nbits) to = 1;
    endtask

    task automatic test_reset();
        logic [63:0] got, e;
        int fc, ur, eur, rise_cyc;
        bit to;
        iVALID = 0;
        iMUTE = 0;
        @(negedge iCLK);
        iRESET_n = 0;
        #1;
        n_cmp++;
        if ({oMCLK, oBCLK, oLRCLK, oSDOUT, oUNDERRUN, oREADY} !== 6'b001001) begin
            n_fail++;
            $display("FAIL reset_values got=%b want=001001",
                     {oMCLK, oBCLK, oLRCLK, oSDOUT, oUNDERRUN, oREADY});
        end
        repeat (3) @(negedge iCLK);
        iRESET_n = 1;
        exp_q.delete();
        last_p = '0;
        mute_model = 0;
        @(posedge iCLK); #1;
        n_cmp++;
        if (oMCLK !== 1'b1) begin
            n_fail++;
            $display("FAIL mclk_c1 got=%b want=1", oMCLK);
        end
        @(posedge iCLK); #1;
        n_cmp++;
        if (oMCLK !== 1'b0) begin
            n_fail++;
            $display("FAIL mclk_c2 got=%b want=0", oMCLK);
        end
        rise_cyc = -1;
        for (int i = 0; i < 50 && rise_cyc < 0; i++) begin
            @(negedge iCLK);
            if (oBCLK) rise_cyc = cyc;
        end
        n_cmp++;
        if (rise_cyc !== 8) begin
            n_fail++;
            $display("FAIL first_bclk_rise got=%0d want=8", rise_cyc);
        end
        for (int f = 0; f < 2; f++) begin
            capture_frame(64, got, fc, ur, to);
            model_next(e, eur);
            n_cmp++;
            if (to || fc !== 16 + 1024 * f) begin
                n_fail++;
                $display("FAIL idle_fall_cycle got=%0d want=%0d to=%0d", fc, 16 + 1024 * f, to);
            end
            n_cmp++;
            if (ur !== eur || got !== e) begin
                n_fail++;
                $display("FAIL idle_frame got=%h/%0d want=%h/%0d", got, ur, e, eur);
            end
        end
    endtask

    task automatic test_single();
        logic [63:0] got, e;
        int fc, ur, eur, acc;
        bit to;
        do_reset();
        push_pair(16'hA5C3, 16'h8001, acc);
        capture_frame(64, got, fc, ur, to);
        model_next(e, eur);
        n_cmp++;
        if (to || got !== e) begin
            n_fail++;
            $display("FAIL single_data got=%h want=%h to=%0d", got, e, to);
        end
        n_cmp++;
        if (ur !== 0 || eur !== 0) begin
            n_fail++;
            $display("FAIL single_underrun got=%0d want=0", ur);
        end
    endtask

    task automatic test_back_to_back();
        int acc5;
        do_reset();
        acc5 = -1;
        fork
            begin
                int acc;
                for (int i = 0; i < 5; i++) begin
                    push_pair(16'h1000 + 16'(i) * 16'h0111, 16'hF00F ^ 16'(i << 4), acc);
                    if (i == 3) begin
                        n_cmp++;
                        if (oREADY !== 1'b0) begin
                            n_fail++;
                            $display("FAIL ready_full got=%b want=0", oREADY);
                        end
                    end
                    if (i == 4) acc5 = acc;
                end
            end
            begin
                logic [63:0] got, e;
                int fc, ur, eur;
                bit to;
                for (int f = 0; f < 5; f++) begin
                    capture_frame(64, got, fc, ur, to);
                    model_next(e, eur);
                    n_cmp++;
                    if (to || got !== e || ur !== eur) begin
                        n_fail++;
                        $display("FAIL b2b_frame%0d got=%h/%0d want=%h/%0d", f, got, ur, e, eur);
                    end
                end
            end
        join
        n_cmp++;
        if (acc5 !== 17) begin
            n_fail++;
            $display("FAIL b2b_fifth_accept got=%0d want=17", acc5);
        end
    endtask

    task automatic test_underrun();
        logic [63:0] got, e;
        int fc, ur, eur, acc;
        bit to;
        capture_frame(64, got, fc, ur, to);
        model_next(e, eur);
        n_cmp++;
        if (to || got !== e) begin
            n_fail++;
            $display("FAIL starve_repeat got=%h want=%h", got, e);
        end
        n_cmp++;
        if (ur !== 1 || eur !== 1) begin
            n_fail++;
            $display("FAIL starve_pulse got=%0d want=1", ur);
        end
        push_pair(16'h7FFE, 16'h0101, acc);
        capture_frame(64, got, fc, ur, to);
        model_next(e, eur);
        n_cmp++;
        if (to || got !== e || ur !== eur) begin
            n_fail++;
            $display("FAIL refill_frame got=%h/%0d want=%h/%0d", got, ur, e, eur);
        end
    endtask

    task automatic test_mute();
        logic [63:0] got, e;
        int fc, ur, eur, acc;
        bit to;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            push_pair(16'hC000 | 16'(i * 3 + 1), 16'h0C00 | 16'(i * 5 + 2), acc);
        end
        n_cmp++;
        if (oREADY !== 1'b0) begin
            n_fail++;
            $display("FAIL mute_full got=%b want=0", oREADY);
        end
        iMUTE = 1;
        mute_model = 1;
        for (int f = 0; f < 4; f++) begin
            capture_frame(64, got, fc, ur, to);
            model_next(e, eur);
            if (f == 1) begin
                iMUTE = 0;
                mute_model = 0;
            end
            n_cmp++;
            if (to || got !== e || ur !== eur) begin
                n_fail++;
                $display("FAIL mute_frame%0d got=%h/%0d want=%h/%0d", f, got, ur, e, eur);
            end
            if (f == 0) begin
                n_cmp++;
                if (oREADY !== 1'b1) begin
                    n_fail++;
                    $display("FAIL mute_pop got=%b want=1", oREADY);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [63:0] got, e;
        int fc, ur, eur, acc;
        bit to;
        do_reset();
        push_pair(16'h1234, 16'hFEDC, acc);
        capture_frame(41, got, fc, ur, to);
        model_next(e, eur);
        n_cmp++;
        if (to || got[40:0] !== e[40:0]) begin
            n_fail++;
            $display("FAIL mid_partial got=%h want=%h", got[40:0], e[40:0]);
        end
        #2;
        iRESET_n = 0;
        #1;
        n_cmp++;
        if ({oMCLK, oBCLK, oLRCLK, oSDOUT, oUNDERRUN, oREADY} !== 6'b001001) begin
            n_fail++;
            $display("FAIL mid_reset_values got=%b want=001001",
                     {oMCLK, oBCLK, oLRCLK, oSDOUT, oUNDERRUN, oREADY});
        end
        repeat (3) @(posedge iCLK);
        @(negedge iCLK);
        iRESET_n = 1;
        exp_q.delete();
        last_p = '0;
        mute_model = 0;
        capture_frame(64, got, fc, ur, to);
        model_next(e, eur);
        n_cmp++;
        if (to || fc !== 16) begin
            n_fail++;
            $display("FAIL mid_restart_fall got=%0d want=16", fc);
        end
        n_cmp++;
        if (got !== e || ur !== eur) begin
            n_fail++;
            $display("FAIL mid_restart_frame got=%h/%0d want=%h/%0d", got, ur, e, eur);
        end
        push_pair(16'h0F0F, 16'hAAAA, acc);
        capture_frame(64, got, fc, ur, to);
        model_next(e, eur);
        n_cmp++;
        if (to || got !== e || ur !== eur) begin
            n_fail++;
            $display("FAIL mid_resume got=%h/%0d want=%h/%0d", got, ur, e, eur);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_underrun();
        test_mute();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
